// File: rtl/layer2_skid_buffer.sv
// layer2_skid_buffer: two-entry valid/ready skid buffer between the
// combinational layer-2 neuron outputs and the layer-3 neuron inputs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   s_valid    upstream vector valid
//   s_ready    registered accept flag (no combinational path from m_ready)
//   s_data     layer-2 outputs, bit i = neuron i
//   m_valid    downstream vector valid
//   m_ready    layer-3 accepts m_data
//   m_data     registered vector to layer 3
//   stall_cnt  saturating count of m_valid && !m_ready cycles
//              (present only with LAYER2_STALL_CNT_EN defined)
//
// Optional feature macro: LAYER2_STALL_CNT_EN
module layer2_skid_buffer #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [OUT_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data
`ifdef LAYER2_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OUT_WIDTH-1:0] main_q;
    logic [OUT_WIDTH-1:0] main_nxt;
    logic [OUT_WIDTH-1:0] skid_q;
    logic [OUT_WIDTH-1:0] skid_nxt;
    logic                 s_ready_nxt;
    logic                 xfer_in;
    logic                 xfer_out;

    assign m_valid  = (state != EMPTY);
    assign m_data   = main_q;
    assign xfer_in  = s_valid && s_ready;
    assign xfer_out = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        unique case (state)
            EMPTY: begin
                if (xfer_in) begin
                    state_nxt = ONE;
                    main_nxt  = s_data;
                end
            end
            ONE: begin
                if (xfer_in && !xfer_out) begin
                    state_nxt = TWO;
                    skid_nxt  = s_data;
                end else if (xfer_in && xfer_out) begin
                    main_nxt  = s_data;
                end else if (xfer_out) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (xfer_out) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        // Ready is registered from the next state so that it never
        // depends combinationally on m_ready.
        s_ready_nxt = (state_nxt != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            s_ready <= s_ready_nxt;
        end
    end

`ifdef LAYER2_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer2_skid_buffer.sv
// tb_layer2_skid_buffer: scoreboard bench for layer2_skid_buffer.
// Inputs change 1ns after rising edges; the monitor samples on falling edges.
module tb_layer2_skid_buffer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
`ifdef LAYER2_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    layer2_skid_buffer #(.OUT_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef LAYER2_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes seen here complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                chk("sb_avail", {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0)
                    chk("order", {16'd0, m_data}, {16'd0, sb_q.pop_front()});
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (s_valid && s_ready)
                sb_q.push_back(s_data);
        end
    end

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_data", {16'd0, m_data}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_s_ready", {31'd0, s_ready}, 32'd0);
        step();
    endtask

    initial begin
        // Reset with s_valid held high: nothing may be taken on release.
        s_valid = 1'b1;
        s_data  = 16'h1234;
        do_reset();
        s_valid = 1'b0;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);

        // One-cycle latency then a back-to-back stream.
        s_valid = 1'b1;
        s_data  = 16'hA5A5;
        m_ready = 1'b1;
        step();
        chk("lat_m_valid", {31'd0, m_valid}, 32'd1);
        chk("lat_m_data", {16'd0, m_data}, 32'h0000A5A5);
        for (int i = 1; i <= 8; i++) begin
            s_data = 16'(i);
            step();
            chk("stream_valid", {31'd0, m_valid}, 32'd1);
            chk("stream_data", {16'd0, m_data}, 32'(i));
        end
        s_valid = 1'b0;
        step();
        chk("stream_drain", {31'd0, m_valid}, 32'd0);

        // Fill both entries with downstream stalled.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0001;
        step();
        chk("one_s_ready", {31'd0, s_ready}, 32'd1);
        s_data = 16'h0002;
        step();
        chk("two_s_ready", {31'd0, s_ready}, 32'd0);
        chk("two_m_data", {16'd0, m_data}, 32'h00000001);
        s_valid = 1'b0;
        s_data  = 16'hDEAD;
        step();
        chk("two_hold", {16'd0, m_data}, 32'h00000001);
        m_ready = 1'b1;
        step();
        chk("drain_2", {16'd0, m_data}, 32'h00000002);
        chk("drain_s_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk("drain_empty", {31'd0, m_valid}, 32'd0);

        // Reset while two vectors are buffered.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h00FF;
        step();
        s_data = 16'hFF00;
        step();
        s_valid = 1'b0;
        chk("pre_rst_two", {31'd0, s_ready}, 32'd0);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flushed", {31'd0, m_valid}, 32'd0);
        end

        // Random traffic, order and hold stability checked by the monitor.
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        step();
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rand_m_valid", {31'd0, m_valid}, 32'd0);

`ifdef LAYER2_STALL_CNT_EN
        do_reset();
        chk("stall_rst0", {16'd0, stall_cnt}, 32'd0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0BAD;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 70000; i++)
            step();
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        #1 rst = 1'b1;
        #1;
        chk("stall_rst", {16'd0, stall_cnt}, 32'd0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
